// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer
//   Upstream sequencer for an 8x1 bit-select mux. A word accepted over a
//   valid/ready handshake is held on `word` while `sel` walks all eight bit
//   positions, BIT_PERIOD clocks per position, serialising the word through
//   the mux. bit_valid/bit_last qualify the mux output.
//
// Parameters
//   MSB_FIRST   0: sel steps 0->7, 1: sel steps 7->0
//   BIT_PERIOD  clocks each sel value is held (1..255)
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   load_valid  load_data valid
//   load_ready  a word can be accepted this cycle (combinational)
//   load_data   word to serialise
//   abort       synchronous cancel of the current word
//   word        held word, drives mux in[7:0]
//   sel         current bit index, drives mux sel[2:0]
//   bit_valid   mux output is a valid serial bit this cycle
//   bit_last    current bit is the final bit of the word
//   busy        sequencer is sending
module mux_sel_sequencer #(
   parameter bit          MSB_FIRST  = 1'b0,
   parameter int unsigned BIT_PERIOD = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_valid,
   output logic       load_ready,
   input  logic [7:0] load_data,
   input  logic       abort,
   output logic [7:0] word,
   output logic [2:0] sel,
   output logic       bit_valid,
   output logic       bit_last,
   output logic       busy
);

   localparam int unsigned CW      = (BIT_PERIOD < 2) ? 1 : $clog2(BIT_PERIOD + 1);
   localparam logic [2:0]  FIRST   = MSB_FIRST ? 3'd7 : 3'd0;
   localparam logic [2:0]  LAST    = MSB_FIRST ? 3'd0 : 3'd7;
   localparam logic [CW-1:0] CNT_MAX = CW'(BIT_PERIOD - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          period_done;
   logic          at_last;
   logic          accept;

   always_comb begin
      period_done = (cnt == CNT_MAX);
      at_last     = (sel == LAST);
      // Ready in IDLE, or in the final clock of the final bit so the next
      // word follows with no idle cycle; abort and reset both block it.
      load_ready  = rst_n && !abort &&
                    ((state == IDLE) || (state == SEND && at_last && period_done));
      accept      = load_valid && load_ready;
      bit_valid   = (state == SEND);
      busy        = (state == SEND);
      bit_last    = (state == SEND) && at_last;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         word  <= '0;
         sel   <= FIRST;
         cnt   <= '0;
      end else if (abort) begin
         // word is deliberately kept; only the sequencing state is cleared
         state <= IDLE;
         sel   <= FIRST;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  word  <= load_data;
                  sel   <= FIRST;
                  cnt   <= '0;
                  state <= SEND;
               end
            end
            SEND: begin
               if (!period_done) begin
                  cnt <= cnt + CW'(1);
               end else begin
                  cnt <= '0;
                  if (!at_last) begin
                     sel <= MSB_FIRST ? (sel - 3'd1) : (sel + 3'd1);
                  end else if (accept) begin
                     word <= load_data;
                     sel  <= FIRST;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// tb_mux_sel_sequencer
//   Directed bench for mux_sel_sequencer. Two instances share the clock:
//   u0 (MSB_FIRST=0, BIT_PERIOD=1) and u1 (MSB_FIRST=1, BIT_PERIOD=3).
//   Inputs change and outputs are sampled on the falling edge.
module tb_mux_sel_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // instance 0: LSB first, one clock per bit
   logic       rst_n0, load_valid0, load_ready0, abort0;
   logic [7:0] load_data0, word0;
   logic [2:0] sel0;
   logic       bit_valid0, bit_last0, busy0;

   // instance 1: MSB first, three clocks per bit
   logic       rst_n1, load_valid1, load_ready1, abort1;
   logic [7:0] load_data1, word1;
   logic [2:0] sel1;
   logic       bit_valid1, bit_last1, busy1;

   mux_sel_sequencer #(.MSB_FIRST(1'b0), .BIT_PERIOD(1)) u0 (
      .clk(clk), .rst_n(rst_n0), .load_valid(load_valid0), .load_ready(load_ready0),
      .load_data(load_data0), .abort(abort0), .word(word0), .sel(sel0),
      .bit_valid(bit_valid0), .bit_last(bit_last0), .busy(busy0)
   );

   mux_sel_sequencer #(.MSB_FIRST(1'b1), .BIT_PERIOD(3)) u1 (
      .clk(clk), .rst_n(rst_n1), .load_valid(load_valid1), .load_ready(load_ready1),
      .load_data(load_data1), .abort(abort1), .word(word1), .sel(sel1),
      .bit_valid(bit_valid1), .bit_last(bit_last1), .busy(busy1)
   );

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [14:0] obs, exp;
      rst_n0 = 1'b0; rst_n1 = 1'b0;
      load_valid0 = 1'b0; load_valid1 = 1'b0;
      abort0 = 1'b0; abort1 = 1'b0;
      load_data0 = 8'h00; load_data1 = 8'h00;
      @(negedge clk);
      tick();
      tick();
      total++;
      if ({load_ready0, load_ready1} !== 2'b00) begin
         bad++;
         $display("FAIL reset_ready_low: got %b want 00", {load_ready0, load_ready1});
      end
      rst_n0 = 1'b1; rst_n1 = 1'b1;
      #1;
      // {bit_valid,busy,bit_last,load_ready,sel,word}
      obs = {bit_valid0, busy0, bit_last0, load_ready0, sel0, word0};
      exp = {4'b0001, 3'd0, 8'h00};
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL reset_u0: got %h want %h", obs, exp);
      end
      obs = {bit_valid1, busy1, bit_last1, load_ready1, sel1, word1};
      exp = {4'b0001, 3'd7, 8'h00};
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL reset_u1: got %h want %h", obs, exp);
      end
   endtask

   task automatic test_lsb_serial();
      logic exp_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      load_valid0 = 1'b1; load_data0 = 8'hA5;
      tick();
      load_valid0 = 1'b0; load_data0 = 8'h00;
      for (int i = 0; i < 8; i++) begin
         #1;
         total++;
         if ({bit_valid0, busy0, sel0, word0[sel0], bit_last0, load_ready0} !==
             {2'b11, 3'(i), exp_bits[i], (i == 7), (i == 7)}) begin
            bad++;
            $display("FAIL lsb_bit%0d: got v=%b b=%b sel=%0d out=%b last=%b rdy=%b want sel=%0d out=%b last=%b",
                     i, bit_valid0, busy0, sel0, word0[sel0], bit_last0, load_ready0,
                     i, exp_bits[i], (i == 7));
         end
         tick();
      end
      total++;
      if ({bit_valid0, busy0, bit_last0, load_ready0, sel0, word0} !== {4'b0001, 3'd7, 8'hA5}) begin
         bad++;
         $display("FAIL lsb_end: got v=%b b=%b l=%b r=%b sel=%0d word=%h want 0 0 0 1 7 a5",
                  bit_valid0, busy0, bit_last0, load_ready0, sel0, word0);
      end
   endtask

   task automatic test_msb_period3();
      int valid_cycles = 0;
      logic [2:0] exp_sel;
      load_valid1 = 1'b1; load_data1 = 8'h80;
      tick();
      load_valid1 = 1'b0;
      for (int i = 0; i < 24; i++) begin
         exp_sel = 3'(7 - i / 3);
         if (bit_valid1) valid_cycles++;
         total++;
         if ({sel1, word1[sel1], bit_last1, load_ready1} !==
             {exp_sel, (i < 3), (exp_sel == 3'd0), (i == 23)}) begin
            bad++;
            $display("FAIL msb_cyc%0d: got sel=%0d out=%b last=%b rdy=%b want sel=%0d out=%b last=%b rdy=%b",
                     i, sel1, word1[sel1], bit_last1, load_ready1,
                     exp_sel, (i < 3), (exp_sel == 3'd0), (i == 23));
         end
         tick();
      end
      total++;
      if (valid_cycles != 24 || bit_valid1 !== 1'b0) begin
         bad++;
         $display("FAIL msb_duration: got valid=%0d trailing_v=%b want 24 0", valid_cycles, bit_valid1);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_word;
      load_valid0 = 1'b1; load_data0 = 8'h3C;
      tick();
      for (int i = 0; i < 16; i++) begin
         // C3 is offered early; it must not disturb 3C before the last bit
         if (i == 4) load_data0 = 8'hC3;
         if (i == 8) load_valid0 = 1'b0;
         #1;
         exp_word = (i < 8) ? 8'h3C : 8'hC3;
         total++;
         if ({bit_valid0, sel0, word0, load_ready0} !==
             {1'b1, 3'(i % 8), exp_word, (i % 8 == 7)}) begin
            bad++;
            $display("FAIL b2b_cyc%0d: got v=%b sel=%0d word=%h rdy=%b want 1 %0d %h %b",
                     i, bit_valid0, sel0, word0, load_ready0, i % 8, exp_word, (i % 8 == 7));
         end
         tick();
      end
      total++;
      if (bit_valid0 !== 1'b0) begin
         bad++;
         $display("FAIL b2b_end: got v=%b want 0", bit_valid0);
      end
   endtask

   task automatic test_abort();
      load_valid0 = 1'b1; load_data0 = 8'h5A;
      tick();
      load_valid0 = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      total++;
      if ({bit_valid0, sel0} !== {1'b1, 3'd4}) begin
         bad++;
         $display("FAIL abort_setup: got v=%b sel=%0d want 1 4", bit_valid0, sel0);
      end
      abort0 = 1'b1; load_valid0 = 1'b1; load_data0 = 8'hFF;
      #1;
      total++;
      if (load_ready0 !== 1'b0) begin
         bad++;
         $display("FAIL abort_ready: got %b want 0", load_ready0);
      end
      tick();
      abort0 = 1'b0;
      #1;
      total++;
      if ({bit_valid0, busy0, sel0, word0, load_ready0} !== {2'b00, 3'd0, 8'h5A, 1'b1}) begin
         bad++;
         $display("FAIL abort_idle: got v=%b b=%b sel=%0d word=%h rdy=%b want 0 0 0 5a 1",
                  bit_valid0, busy0, sel0, word0, load_ready0);
      end
      tick();
      load_valid0 = 1'b0;
      total++;
      if ({bit_valid0, sel0, word0} !== {1'b1, 3'd0, 8'hFF}) begin
         bad++;
         $display("FAIL abort_reload: got v=%b sel=%0d word=%h want 1 0 ff", bit_valid0, sel0, word0);
      end
      for (int i = 0; i < 8; i++) tick();
      total++;
      if ({bit_valid0, sel0} !== {1'b0, 3'd7}) begin
         bad++;
         $display("FAIL abort_drain: got v=%b sel=%0d want 0 7", bit_valid0, sel0);
      end
   endtask

   task automatic test_reset_mid_send();
      load_valid0 = 1'b1; load_data0 = 8'h96;
      tick();
      load_valid0 = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      total++;
      if (sel0 !== 3'd5) begin
         bad++;
         $display("FAIL rstmid_setup: got sel=%0d want 5", sel0);
      end
      rst_n0 = 1'b0;
      tick();
      total++;
      if ({bit_valid0, busy0, bit_last0, load_ready0, sel0, word0} !== {4'b0000, 3'd0, 8'h00}) begin
         bad++;
         $display("FAIL rstmid_vals: got v=%b b=%b l=%b r=%b sel=%0d word=%h want 0 0 0 0 0 00",
                  bit_valid0, busy0, bit_last0, load_ready0, sel0, word0);
      end
      rst_n0 = 1'b1;
      load_valid0 = 1'b1; load_data0 = 8'h3B;
      tick();
      load_valid0 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         total++;
         if ({bit_valid0, sel0, word0} !== {1'b1, 3'(i), 8'h3B}) begin
            bad++;
            $display("FAIL rstmid_bit%0d: got v=%b sel=%0d word=%h want 1 %0d 3b",
                     i, bit_valid0, sel0, word0, i);
         end
         tick();
      end
      total++;
      if (bit_valid0 !== 1'b0) begin
         bad++;
         $display("FAIL rstmid_end: got v=%b want 0", bit_valid0);
      end
   endtask

   initial begin
      test_reset();
      test_lsb_serial();
      test_msb_period3();
      test_back_to_back();
      test_abort();
      test_reset_mid_send();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
